// File: rtl/contador_palabras.sv
// Word counter for the four output FIFOs plus a total, read back through a req/idx port.
// Optional macro CONTADOR_SATURATE_EN: counters saturate instead of wrapping.
module contador_palabras #(
  parameter int CNT_W = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Enable,
  input  logic [3:0]       pop_fifo_azules,
  input  logic [3:0]       empty_azules,
  input  logic             idle,
  input  logic             req,
  input  logic [IDX_W-1:0] idx,
  output logic [CNT_W-1:0] salida_contador,
  output logic             valid_contador
);

  typedef enum logic {RD_IDLE, RD_PEND} rd_state_t;

  rd_state_t        state;
  logic [IDX_W-1:0] pend_idx;
  logic [CNT_W-1:0] cnt [5];
  logic [3:0]       ev;
  logic [CNT_W-1:0] pc;
  logic [CNT_W:0]   tot_sum;

  // A pop on an empty FIFO moves no word, so it is not counted.
  assign ev = {4{Enable}} & pop_fifo_azules & ~empty_azules;
  assign pc = CNT_W'(ev[0]) + CNT_W'(ev[1]) + CNT_W'(ev[2]) + CNT_W'(ev[3]);
  assign tot_sum = {1'b0, cnt[4]} + {1'b0, pc};

  function automatic logic [CNT_W-1:0] rd_mux(input logic [IDX_W-1:0] i);
    case (i)
      IDX_W'(0): return cnt[0];
      IDX_W'(1): return cnt[1];
      IDX_W'(2): return cnt[2];
      IDX_W'(3): return cnt[3];
      IDX_W'(4): return cnt[4];
      default:   return '0;
    endcase
  endfunction

  // NOTE: the counter array is small and architecturally visible, so it is reset like any register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
`ifdef CONTADOR_SATURATE_EN
        if (ev[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
`else
        if (ev[i]) cnt[i] <= cnt[i] + 1'b1;
`endif
      end
`ifdef CONTADOR_SATURATE_EN
      cnt[4] <= tot_sum[CNT_W] ? '1 : tot_sum[CNT_W-1:0];
`else
      cnt[4] <= tot_sum[CNT_W-1:0];
`endif
    end
  end

  // NOTE: non-blocking assignments make every read see the pre-increment counter value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= RD_IDLE;
      pend_idx        <= '0;
      salida_contador <= '0;
      valid_contador  <= 1'b0;
    end else begin
      valid_contador <= 1'b0;
      if (Enable) begin
        case (state)
          RD_IDLE: begin
            if (req && idle) begin
              salida_contador <= rd_mux(idx);
              valid_contador  <= 1'b1;
            end else if (req) begin
              pend_idx <= idx;
              state    <= RD_PEND;
            end
          end
          RD_PEND: begin
            // A request arriving in the serving cycle is dropped.
            if (idle) begin
              salida_contador <= rd_mux(pend_idx);
              valid_contador  <= 1'b1;
              state           <= RD_IDLE;
            end else if (req) begin
              pend_idx <= idx;
            end
          end
          default: state <= RD_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_contador_palabras.sv
// Self-checking bench for contador_palabras: directed steps plus a random phase
// checked against per-FIFO word totals kept as plain integers.
module tb_contador_palabras;

  localparam int CNT_W = 8;
  localparam int IDX_W = 3;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             Enable;
  logic [3:0]       pop_fifo_azules;
  logic [3:0]       empty_azules;
  logic             idle;
  logic             req;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] salida_contador;
  logic             valid_contador;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: total words popped per FIFO (unbounded) and the pending read.
  int               tot [4];
  bit               pend;
  logic [IDX_W-1:0] pidx;
  logic [CNT_W-1:0] exp_d;
  logic             exp_v;

  contador_palabras #(.CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .Enable          (Enable),
    .pop_fifo_azules (pop_fifo_azules),
    .empty_azules    (empty_azules),
    .idle            (idle),
    .req             (req),
    .idx             (idx),
    .salida_contador (salida_contador),
    .valid_contador  (valid_contador)
  );

  always #5 clk = ~clk;

  function automatic int fold(input int t);
`ifdef CONTADOR_SATURATE_EN
    return (t > MAXV) ? MAXV : t;
`else
    return t % (MAXV + 1);
`endif
  endfunction

  function automatic logic [CNT_W-1:0] model_read(input logic [IDX_W-1:0] i);
    if (i < 4) return CNT_W'(fold(tot[i]));
    if (i == 4) return CNT_W'(fold(tot[0] + tot[1] + tot[2] + tot[3]));
    return '0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    Enable = 1'b0; pop_fifo_azules = '0; empty_azules = '0;
    idle = 1'b0; req = 1'b0; idx = '0;
    for (int i = 0; i < 4; i++) tot[i] = 0;
    pend = 1'b0; pidx = '0; exp_d = '0; exp_v = 1'b0;
    #1;
    check("reset_valid", 32'(valid_contador), 32'(0));
    check("reset_data", 32'(salida_contador), 32'(0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input logic en, input logic [3:0] pop, input logic [3:0] emp,
                      input logic idl, input logic rq, input logic [IDX_W-1:0] ix);
    @(negedge clk);
    Enable = en; pop_fifo_azules = pop; empty_azules = emp;
    idle = idl; req = rq; idx = ix;
    exp_v = 1'b0;
    if (en) begin
      if (!pend) begin
        if (rq && idl) begin exp_v = 1'b1; exp_d = model_read(ix); end
        else if (rq) begin pend = 1'b1; pidx = ix; end
      end else begin
        if (idl) begin exp_v = 1'b1; exp_d = model_read(pidx); pend = 1'b0; end
        else if (rq) pidx = ix;
      end
      for (int i = 0; i < 4; i++) if (pop[i] && !emp[i]) tot[i]++;
    end
    @(posedge clk);
    #1;
    check("valid", 32'(valid_contador), 32'(exp_v));
    check("data", 32'(salida_contador), 32'(exp_d));
  endtask

  task automatic read_all();
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, IDX_W'(i));
    step(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);
  endtask

  initial begin
    reset = 1'b0;
    do_reset();

    // Seven pops on each FIFO, then read 0..4 back to back.
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 7; k++) step(1'b1, 4'(1 << f), 4'b0000, 1'b1, 1'b0, '0);
    read_all();
    check("cnt4_is_0x1c", 32'(exp_d), 32'h1C);

    // Simultaneous pops with FIFO2 empty.
    step(1'b1, 4'b1111, 4'b0100, 1'b1, 1'b0, '0);
    read_all();

    // Pending read of the total while the main FSM is busy, with pops in flight.
    for (int k = 0; k < 5; k++) step(1'b1, 4'b0011, 4'b0000, 1'b0, 1'b1, IDX_W'(4));
    step(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);
    step(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);

    // Pending overwrite, then a request dropped in the serving cycle.
    step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, IDX_W'(0));
    step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, IDX_W'(2));
    step(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, IDX_W'(3));
    step(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);

    // Invalid index, then Enable low ignoring requests and pops.
    step(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, IDX_W'(6));
    check("invalid_idx_zero", 32'(salida_contador), 32'(0));
    for (int k = 0; k < 3; k++) step(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, IDX_W'(1));
    read_all();

    // Reset in the middle of a pending read discards it.
    step(1'b1, 4'b1010, 4'b0000, 1'b0, 1'b1, IDX_W'(1));
    do_reset();
    step(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);
    read_all();

    // 257 counted pops on FIFO3 cross the counter limit.
    for (int k = 0; k < 257; k++) step(1'b1, 4'b1000, 4'b0000, 1'b1, 1'b0, '0);
    step(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, IDX_W'(3));
`ifdef CONTADOR_SATURATE_EN
    check("wrap_idx3", 32'(salida_contador), 32'hFF);
`else
    check("wrap_idx3", 32'(salida_contador), 32'h01);
`endif
    read_all();

    // Random traffic against the reference totals.
    for (int k = 0; k < 600; k++)
      step(($urandom_range(0, 7) != 0), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 2) != 0), 1'($urandom), IDX_W'($urandom));
    read_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
